data_memory_hs: RTL and testbench
=================================

Name: data_memory_hs

Overview:
- Parametrised data memory for the pipelined CPU's MEM stage.
- Byte-addressed, with per-byte write enables.
- Configurable access latency behind a req/ready/valid handshake; the CPU stall logic uses busy_o.
- Detects misaligned and out-of-range accesses and reports them without corrupting memory.

Parameters:
DATA_W, 32, word width in bits; multiple of 8, at least 16
DEPTH, 256, number of words; power of two
LATENCY, 2, cycles from request acceptance to response; at least 1

Ports:
clk_i  input  1  clock, all state updates on the rising edge
rst_i  input  1  reset, synchronous, active-high
req_i  input  1  access request
we_i  input  1  1 = write, 0 = read
be_i  input  DATA_W/8  byte-lane write enables (writes only)
addr_i  input  32  byte address
data_i  input  DATA_W  write data
ready_o  output  1  request can be accepted this cycle
busy_o  output  1  transaction outstanding (state WAIT, or state RESP with no new accept)
valid_o  output  1  one-cycle response pulse
data_o  output  DATA_W  read data
err_o  output  1  response error, qualified by valid_o

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high, on rst_i.
- Reset values:
  - state = IDLE; ready_o = 1; valid_o = 0; err_o = 0; data_o = 0; counter = 0.
  - Memory contents are not reset.
- Address decoding:
  - LSB = log2(DATA_W/8).
  - Word index = addr_i[LSB +: log2(DEPTH)].
  - Misaligned: addr_i[LSB-1:0] is not 0.
  - Out-of-range: addr_i >> LSB is at least DEPTH.
- Accept: req_i && ready_o at a rising edge. This latches we, be, word index, data and error.
- State IDLE:
  - ready_o = 1.
  - On accept: go to RESP if LATENCY == 1, else go to WAIT with counter = LATENCY-1.
- State WAIT:
  - ready_o = 0.
  - Counter decrements each cycle; when counter == 1, go to RESP.
  - req_i is ignored.
- State RESP:
  - valid_o = 1 for exactly this cycle.
  - ready_o = 1, so a new accept here goes directly to WAIT or RESP. This gives back-to-back throughput of one transaction per LATENCY cycles.
  - With no accept, return to IDLE.
- Latency: valid_o is high exactly LATENCY cycles after the accept edge. Example: accept at edge N, LATENCY=2 gives valid_o during cycle N+2.
- Memory update: on the edge entering RESP, the latched write is applied to lanes whose be bit is 1. All-zero be is a legal no-op write that still gets a response.
- Read data:
  - data_o is loaded on the edge entering RESP with the memory word, all lanes, be ignored.
  - Writes load data_o = 0.
  - data_o holds its value until the next response.
- Error:
  - An errored transaction takes the same latency, performs no write, returns data_o = 0 and err_o = 1.
  - err_o = 0 on good responses.
- Read-after-write: a read accepted in the RESP cycle of a write to the same word returns the newly written data.
- Reset mid-transaction: rst_i wins over everything. The pending transaction is dropped, no write is applied even at the RESP-entry edge, and no valid_o is produced.
- Counter width is log2(LATENCY)+1; there is no wrap, since the counter is reloaded only on accept.

Decomposition:
- Shared package data_mem_pkg holds:
  - state enum {IDLE, WAIT, RESP};
  - function computing LSB from DATA_W;
  - constant BE_W = DATA_W/8.
- One natural sub-module, data_mem_array:
  - DEPTH x DATA_W storage, per-lane write enable, synchronous read registered in the same edge;
  - the FSM and handshake stay in the top.

Test Plan:
- Reset, then a 5-cycle idle period → ready_o=1, valid_o=0, data_o=0, err_o=0 throughout.
- LATENCY=2:
  - write 0xDEADBEEF at address 0x10 with be=4'hF, accepted at edge N → valid_o only in cycle N+2, err_o=0;
  - then a read of 0x10 → data_o=0xDEADBEEF exactly 2 cycles after its accept.
- Byte lanes: with word 0x10 = 0xDEADBEEF, write 0x000000AA with be=4'b0001 → a following read returns 0xDEADBEAA; a write with be=0 leaves the word unchanged and still pulses valid_o.
- Errors, DEPTH=256:
  - read of 0x13 (misaligned) → err_o=1 and data_o=0 at latency;
  - write to 0x400 (out of range) → err_o=1, and word 0 read back unchanged.
- Back-to-back: write 0x12345678 to 0x20, then a read of 0x20 issued in the write's RESP cycle → read returns 0x12345678; ready_o=0 in every WAIT cycle; a req_i held during WAIT is accepted only in RESP.
- Reset mid-op: write 0xFFFFFFFF to 0x30 with rst_i asserted in the cycle before RESP → no valid_o, and a subsequent read of 0x30 returns the old value.
- Repeat with LATENCY=1 and DATA_W=64 → valid_o one cycle after accept, with 8 byte lanes honoured.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the handshaked data memory.
// The lane count and lane-select width are derived here so top and array agree.
package data_mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int DATA_W_DEF = 32;
  localparam int BE_W       = DATA_W_DEF / 8;

  function automatic int be_w_of(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int lsb_of(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// DEPTH x DATA_W storage with per-byte write enables and a registered read port.
// The read register can be cleared instead of loaded (write/error responses).
module data_mem_array
  import data_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_en,
  input  logic                         i_we,
  input  logic                         i_clr,
  input  logic [be_w_of(DATA_W)-1:0]   i_be,
  input  logic [$clog2(DEPTH)-1:0]     i_idx,
  input  logic [DATA_W-1:0]            i_wdata,
  output logic [DATA_W-1:0]            o_rdata
);

  localparam int BW = be_w_of(DATA_W);

  logic [BW-1:0][7:0] r_mem [DEPTH];
  logic [DATA_W-1:0]  r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_en && i_we) begin
      for (int i = 0; i < BW; i++) begin
        if (i_be[i]) r_mem[i_idx][i] <= i_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)     r_rdata <= '0;
    else if (i_en) r_rdata <= i_clr ? '0 : r_mem[i_idx];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_memory_hs.sv
// Byte-addressed data memory with fixed access latency behind req/ready/valid.
// Misaligned and out-of-range accesses respond with err_o and never write.
module data_memory_hs
  import data_mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_i,
  input  logic                       we_i,
  input  logic [be_w_of(DATA_W)-1:0] be_i,
  input  logic [31:0]                addr_i,
  input  logic [DATA_W-1:0]          data_i,
  output logic                       ready_o,
  output logic                       busy_o,
  output logic                       valid_o,
  output logic [DATA_W-1:0]          data_o,
  output logic                       err_o
);

  localparam int BW  = be_w_of(DATA_W);
  localparam int LSB = lsb_of(DATA_W);
  localparam int IW  = $clog2(DEPTH);
  localparam int CW  = $clog2(LATENCY) + 1;

  state_t            r_state, w_next;
  logic [CW-1:0]     r_cnt;
  logic              r_we, r_err, r_err_o;
  logic [BW-1:0]     r_be;
  logic [IW-1:0]     r_idx;
  logic [DATA_W-1:0] r_data;

  logic              w_acc, w_err, w_fire, w_from_wait;
  logic              w_s_we, w_s_err;
  logic [BW-1:0]     w_s_be;
  logic [IW-1:0]     w_s_idx;
  logic [DATA_W-1:0] w_s_data;

  assign ready_o = (r_state != WAIT);
  assign w_acc   = req_i && ready_o;
  assign w_err   = (|addr_i[LSB-1:0]) || ((addr_i >> LSB) >= 32'(DEPTH));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_acc) w_next = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (r_cnt == CW'(1)) w_next = RESP;
      RESP:    w_next = w_acc ? ((LATENCY == 1) ? RESP : WAIT) : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // With LATENCY==1 the RESP-entry edge is the accept edge, so use live inputs.
  assign w_from_wait = (r_state == WAIT);
  assign w_s_we   = w_from_wait ? r_we   : we_i;
  assign w_s_err  = w_from_wait ? r_err  : w_err;
  assign w_s_be   = w_from_wait ? r_be   : be_i;
  assign w_s_idx  = w_from_wait ? r_idx  : addr_i[LSB +: IW];
  assign w_s_data = w_from_wait ? r_data : data_i;
  assign w_fire   = (w_next == RESP) && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_be    <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_err_o <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_cnt  <= CW'(LATENCY - 1);
        r_we   <= we_i;
        r_err  <= w_err;
        r_be   <= be_i;
        r_idx  <= addr_i[LSB +: IW];
        r_data <= data_i;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_fire) r_err_o <= w_s_err;
    end
  end

  data_mem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_array (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_en    (w_fire),
    .i_we    (w_s_we && !w_s_err),
    .i_clr   (w_s_we || w_s_err),
    .i_be    (w_s_be),
    .i_idx   (w_s_idx),
    .i_wdata (w_s_data),
    .o_rdata (data_o)
  );

  assign valid_o = (r_state == RESP);
  assign busy_o  = (r_state == WAIT) || ((r_state == RESP) && !w_acc);
  assign err_o   = r_err_o;

endmodule

// File: tb/tb_data_memory_hs.sv
// Bench for data_memory_hs: a 32-bit LATENCY=2 instance and a 64-bit LATENCY=1 instance,
// checked against a byte-level reference memory.
module tb_data_memory_hs;

  logic        clk = 1'b0;
  logic        rst = 1'b1, req_a = 1'b0, req_b = 1'b0, we = 1'b0;
  logic [7:0]  be = '0;
  logic [31:0] addr = '0;
  logic [63:0] wdata = '0;
  logic        ready_a, busy_a, valid_a, err_a;
  logic        ready_b, busy_b, valid_b, err_b;
  logic [31:0] data_a;
  logic [63:0] data_b;
  int          errs = 0, checks = 0;
  bit          sel = 1'b0;
  logic [7:0]  mdl [int];

  always #5 clk = ~clk;

  data_memory_hs #(.DATA_W(32), .DEPTH(256), .LATENCY(2)) dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(req_a), .we_i(we), .be_i(be[3:0]),
    .addr_i(addr), .data_i(wdata[31:0]), .ready_o(ready_a), .busy_o(busy_a),
    .valid_o(valid_a), .data_o(data_a), .err_o(err_a));

  data_memory_hs #(.DATA_W(64), .DEPTH(256), .LATENCY(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(req_b), .we_i(we), .be_i(be),
    .addr_i(addr), .data_i(wdata), .ready_o(ready_b), .busy_o(busy_b),
    .valid_o(valid_b), .data_o(data_b), .err_o(err_b));

  wire        o_ready = sel ? ready_b : ready_a;
  wire        o_busy  = sel ? busy_b  : busy_a;
  wire        o_valid = sel ? valid_b : valid_a;
  wire        o_err   = sel ? err_b   : err_a;
  wire [63:0] o_data  = sel ? data_b  : {32'h0, data_a};

  function automatic int bw(input bit inst);  return inst ? 8 : 4; endfunction
  function automatic int lat_of(input bit inst); return inst ? 1 : 2; endfunction
  function automatic logic [7:0] mask_of(input bit inst); return inst ? 8'hFF : 8'h0F; endfunction
  function automatic int key(input bit inst, input logic [31:0] a);
    return (inst ? 32'h1000_0000 : 0) + int'(a);
  endfunction
  function automatic bit exp_err(input bit inst, input logic [31:0] a);
    return (int'(a) % bw(inst) != 0) || ((int'(a) / bw(inst)) >= 256);
  endfunction
  function automatic logic [63:0] mdl_read(input bit inst, input logic [31:0] a);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < bw(inst); i++) r[8*i +: 8] = mdl[key(inst, a + 32'(i))];
    return r;
  endfunction
  function automatic void mdl_write(input bit inst, input logic [31:0] a,
                                    input logic [7:0] b, input logic [63:0] d);
    if (exp_err(inst, a)) return;
    for (int i = 0; i < bw(inst); i++)
      if (b[i]) mdl[key(inst, a + 32'(i))] = d[8*i +: 8];
  endfunction

  // One transaction; returns cycles from accept to valid (99 if none), data and err.
  task automatic op(input bit inst, input bit w, input logic [7:0] b, input logic [31:0] a,
                    input logic [63:0] d, output int lat, output logic [63:0] rd, output logic er);
    @(negedge clk);
    sel = inst; we = w; be = b; addr = a; wdata = d;
    if (inst) req_b = 1'b1; else req_a = 1'b1;
    @(posedge clk); #1;
    req_a = 1'b0; req_b = 1'b0;
    lat = 99; rd = '0; er = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (o_valid) begin lat = k; rd = o_data; er = o_err; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({ready_a, valid_a, err_a, busy_a, data_a} !== {4'b1000, 32'h0}) begin
        errs++; $display("FAIL reset_a cyc%0d: got %b/%h want 1000/0", c, {ready_a, valid_a, err_a, busy_a}, data_a);
      end
      checks++;
      if ({ready_b, valid_b, err_b, busy_b, data_b} !== {4'b1000, 64'h0}) begin
        errs++; $display("FAIL reset_b cyc%0d: got %b/%h want 1000/0", c, {ready_b, valid_b, err_b, busy_b}, data_b);
      end
    end
  endtask

  task automatic test_write_read(input bit inst);
    int lat; logic [63:0] rd, d; logic er;
    d = inst ? 64'h0123_4567_DEAD_BEEF : 64'hDEAD_BEEF;
    op(inst, 1'b1, mask_of(inst), 32'h10, d, lat, rd, er);
    mdl_write(inst, 32'h10, mask_of(inst), d);
    checks++;
    if (lat !== lat_of(inst) || er !== 1'b0) begin
      errs++; $display("FAIL wr_lat inst%0d: got lat=%0d err=%b want lat=%0d err=0", inst, lat, er, lat_of(inst));
    end
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin
      errs++; $display("FAIL valid_pulse inst%0d: got %b want 0", inst, o_valid);
    end
    op(inst, 1'b0, 8'h0, 32'h10, 64'h0, lat, rd, er);
    checks++;
    if (lat !== lat_of(inst) || rd !== mdl_read(inst, 32'h10) || er !== 1'b0) begin
      errs++; $display("FAIL rd inst%0d: got lat=%0d d=%h err=%b want lat=%0d d=%h", inst, lat, rd, er, lat_of(inst), mdl_read(inst, 32'h10));
    end
  endtask

  task automatic test_lanes(input bit inst);
    int lat; logic [63:0] rd, d; logic er;
    logic [7:0] bes [3];
    bes[0] = 8'h01; bes[1] = 8'h00; bes[2] = inst ? 8'hA0 : 8'h04;
    for (int t = 0; t < 3; t++) begin
      d = (t == 0) ? 64'hAA : {$urandom, $urandom};
      op(inst, 1'b1, bes[t], 32'h10, d, lat, rd, er);
      mdl_write(inst, 32'h10, bes[t], d);
      checks++;
      if (lat !== lat_of(inst) || er !== 1'b0 || rd !== 64'h0) begin
        errs++; $display("FAIL lane_wr inst%0d be=%h: got lat=%0d err=%b d=%h", inst, bes[t], lat, er, rd);
      end
      op(inst, 1'b0, 8'h0, 32'h10, 64'h0, lat, rd, er);
      checks++;
      if (lat !== lat_of(inst) || rd !== mdl_read(inst, 32'h10)) begin
        errs++; $display("FAIL lane_rd inst%0d be=%h: got lat=%0d d=%h want d=%h", inst, bes[t], lat, rd, mdl_read(inst, 32'h10));
      end
    end
  endtask

  task automatic test_errors(input bit inst);
    int lat; logic [63:0] rd, d; logic er;
    logic [31:0] oor;
    oor = inst ? 32'h800 : 32'h400;
    op(inst, 1'b0, 8'h0, 32'h13, 64'h0, lat, rd, er);
    checks++;
    if (lat !== lat_of(inst) || er !== 1'b1 || rd !== 64'h0) begin
      errs++; $display("FAIL misalign inst%0d: got lat=%0d err=%b d=%h want err=1 d=0", inst, lat, er, rd);
    end
    d = {$urandom, $urandom};
    op(inst, 1'b1, mask_of(inst), 32'h0, d, lat, rd, er);
    mdl_write(inst, 32'h0, mask_of(inst), d);
    op(inst, 1'b1, mask_of(inst), oor, ~d, lat, rd, er);
    mdl_write(inst, oor, mask_of(inst), ~d);
    checks++;
    if (lat !== lat_of(inst) || er !== 1'b1 || rd !== 64'h0) begin
      errs++; $display("FAIL oor_wr inst%0d: got lat=%0d err=%b d=%h want err=1 d=0", inst, lat, er, rd);
    end
    op(inst, 1'b0, 8'h0, 32'h0, 64'h0, lat, rd, er);
    checks++;
    if (rd !== mdl_read(inst, 32'h0) || er !== 1'b0) begin
      errs++; $display("FAIL oor_keep inst%0d: got d=%h err=%b want d=%h", inst, rd, er, mdl_read(inst, 32'h0));
    end
  endtask

  task automatic test_back_to_back(input bit inst);
    int lat; logic [63:0] rd, d;
    d = inst ? 64'h9ABC_DEF0_1234_5678 : 64'h1234_5678;
    @(negedge clk);
    sel = inst; we = 1'b1; be = mask_of(inst); addr = 32'h20; wdata = d;
    if (inst) req_b = 1'b1; else req_a = 1'b1;
    @(posedge clk); #1;
    we = 1'b0;
    mdl_write(inst, 32'h20, mask_of(inst), d);
    for (int k = 1; k <= lat_of(inst); k++) begin
      @(negedge clk);
      checks++;
      if (k < lat_of(inst)) begin
        if ({o_ready, o_busy, o_valid} !== 3'b010) begin
          errs++; $display("FAIL b2b_wait inst%0d k=%0d: got rdy/busy/vld=%b want 010", inst, k, {o_ready, o_busy, o_valid});
        end
      end else if ({o_ready, o_busy, o_valid, o_err} !== 4'b1010) begin
        errs++; $display("FAIL b2b_resp inst%0d: got rdy/busy/vld/err=%b want 1010", inst, {o_ready, o_busy, o_valid, o_err});
      end
    end
    @(posedge clk); #1;
    req_a = 1'b0; req_b = 1'b0;
    lat = 99; rd = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (o_valid) begin lat = k; rd = o_data; break; end
    end
    checks++;
    if (lat !== lat_of(inst) || rd !== mdl_read(inst, 32'h20)) begin
      errs++; $display("FAIL b2b_rd inst%0d: got lat=%0d d=%h want lat=%0d d=%h", inst, lat, rd, lat_of(inst), mdl_read(inst, 32'h20));
    end
  endtask

  task automatic test_reset_midop(input bit inst);
    int lat; logic [63:0] rd, d; logic er; bit seen;
    d = {$urandom, $urandom};
    op(inst, 1'b1, mask_of(inst), 32'h30, d, lat, rd, er);
    mdl_write(inst, 32'h30, mask_of(inst), d);
    @(negedge clk);
    sel = inst; we = 1'b1; be = mask_of(inst); addr = 32'h30; wdata = '1;
    if (inst) req_b = 1'b1; else req_a = 1'b1;
    if (lat_of(inst) == 1) rst = 1'b1;
    @(posedge clk); #1;
    req_a = 1'b0; req_b = 1'b0;
    if (lat_of(inst) > 1) begin
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (o_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errs++; $display("FAIL rst_novalid inst%0d: got valid seen=%b want 0", inst, seen);
    end
    op(inst, 1'b0, 8'h0, 32'h30, 64'h0, lat, rd, er);
    checks++;
    if (rd !== mdl_read(inst, 32'h30) || lat !== lat_of(inst)) begin
      errs++; $display("FAIL rst_nowrite inst%0d: got d=%h lat=%0d want d=%h", inst, rd, lat, mdl_read(inst, 32'h30));
    end
  endtask

  task automatic test_random(input bit inst);
    int lat, r; logic [63:0] rd, d, ed; logic er, ee, w; logic [31:0] a; logic [7:0] b;
    for (int i = 0; i < 16; i++) begin
      d = {$urandom, $urandom};
      op(inst, 1'b1, mask_of(inst), 32'(i * bw(inst)), d, lat, rd, er);
      mdl_write(inst, 32'(i * bw(inst)), mask_of(inst), d);
    end
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      a = 32'($urandom_range(0, 15) * bw(inst));
      if (r == 0) a = a + 32'($urandom_range(1, bw(inst) - 1));
      if (r == 1) a = 32'((256 + $urandom_range(0, 15)) * bw(inst));
      w = 1'($urandom_range(0, 1));
      b = 8'($urandom);
      d = {$urandom, $urandom};
      ee = exp_err(inst, a);
      ed = (w || ee) ? 64'h0 : mdl_read(inst, a);
      op(inst, w, b, a, d, lat, rd, er);
      if (w) mdl_write(inst, a, b, d);
      checks++;
      if (lat !== lat_of(inst) || er !== ee || rd !== ed) begin
        errs++; $display("FAIL rand inst%0d n=%0d a=%h we=%b: got lat=%0d err=%b d=%h want lat=%0d err=%b d=%h",
                         inst, n, a, w, lat, er, rd, lat_of(inst), ee, ed);
      end
    end
  endtask

  initial begin
    test_reset();
    for (int i = 0; i < 2; i++) begin
      test_write_read(1'(i));
      test_lanes(1'(i));
      test_errors(1'(i));
      test_back_to_back(1'(i));
      test_reset_midop(1'(i));
      test_random(1'(i));
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
